// File: rtl/pulse_bram_write_arbiter.sv
// pulse_bram_write_arbiter: round-robin arbiter sharing one BRAM write port between burst-writing pulse channels
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_last  per-channel beat valid and end-of-burst flag
//   req_addr/req_data   per-channel byte address and write data, slice i = [i*W +: W]
//   req_ready           per-channel accept, decoded from registered state only
//   bram_addr/bram_data_in/bram_we/ena  registered BRAM port A write signals (ena == bram_we)
//   grant_id            current or last granted channel
//   busy                high while a burst owns the port
//   timeout_err         one-cycle pulse when a stalled burst is forcibly released
// Optional feature: define ARB_GRANT_STATS_EN to add grant_cnt (completed bursts per channel)
// and timeout_cnt (forced releases) outputs.
module pulse_bram_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [DATA_W-1:0]         bram_data_in,
    output logic                      bram_we,
    output logic                      ena,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic                      timeout_err
`ifdef ARB_GRANT_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     grant_cnt,
    output logic [31:0]               timeout_cnt
`endif
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            state_q, state_d;
    logic [1:0]        rr_ptr, pick;
    logic              found, sel_valid, sel_last, accept, timeout_hit;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [CW-1:0]     idle_cnt;
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
                sel_data     = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = (state_q == GRANT);
            end
        end
    end
    // Scan from the farthest candidate to the nearest so the channel right after rr_ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
                    found = 1'b1;
                    pick  = 2'(i);
                end
            end
        end
    end
    // The cycle that would bring the idle count to TIMEOUT-1 releases the burst.
    always_comb begin
        accept      = (state_q == GRANT) && sel_valid;
        timeout_hit = (state_q == GRANT) && !sel_valid && (idle_cnt == CW'(TIMEOUT - 2));
        state_d     = (state_q == IDLE) ? (found ? GRANT : IDLE)
                                        : (((accept && sel_last) || timeout_hit) ? IDLE : GRANT);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr       <= 2'(NUM_REQ - 1);
            grant_id     <= '0;
            idle_cnt     <= '0;
            bram_addr    <= '0;
            bram_data_in <= '0;
            bram_we      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bram_we     <= accept;
            timeout_err <= timeout_hit;
            idle_cnt    <= (state_q != GRANT || accept) ? '0 : idle_cnt + 1'b1;
            if (state_q == IDLE && found) grant_id <= pick;
            if (accept) begin
                bram_addr    <= sel_addr;
                bram_data_in <= sel_data;
            end
            if ((accept && sel_last) || timeout_hit) rr_ptr <= grant_id;
        end
    end
    assign ena  = bram_we;
    assign busy = (state_q == GRANT);
`ifdef ARB_GRANT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (accept && sel_last && grant_id == 2'(i))
                    grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
            if (timeout_hit) timeout_cnt <= timeout_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pulse_bram_write_arbiter.sv
// tb_pulse_bram_write_arbiter: scoreboard bench for the BRAM write arbiter
module tb_pulse_bram_write_arbiter;
    localparam int N = 2, AW = 32, DW = 32, TO = 8;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [AW-1:0]   ch_addr [N];
    logic [DW-1:0]   ch_data [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_data_in;
    logic            bram_we, ena, busy, timeout_err;
    logic [1:0]      grant_id;
`ifdef ARB_GRANT_STATS_EN
    logic [N*32-1:0] grant_cnt;
    logic [31:0]     timeout_cnt;
`endif
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = ch_addr[g];
        assign req_data[g*DW +: DW] = ch_data[g];
    end

    pulse_bram_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .bram_addr(bram_addr), .bram_data_in(bram_data_in), .bram_we(bram_we), .ena(ena),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
`ifdef ARB_GRANT_STATS_EN
        , .grant_cnt(grant_cnt), .timeout_cnt(timeout_cnt)
`endif
    );

    typedef struct {int c; logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t wq[$];
    int  gq[$];
    int  tq[$];
    int  total = 0, bad = 0, cyc = 0, nwr = 0, last_wr = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic flag(input string n);
        total++;
        bad++;
        $display("FAIL %s: got unexpected/missing event at cycle %0d", n, cyc);
    endtask

    // Monitor: every output event is matched against the queued expectations.
    initial begin
        bit pb = 1'b0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (bram_we) begin
                nwr++;
                last_wr = cyc;
                if (wq.size() == 0) flag("unexpected_write");
                else begin
                    e = wq.pop_front();
                    chk("wr_cycle", cyc, e.c);
                    chk("wr_addr", bram_addr, e.a);
                    chk("wr_data", bram_data_in, e.d);
                    chk("wr_ena", ena, 1);
                end
            end else if (wq.size() != 0 && wq[0].c <= cyc) begin
                flag("missing_write");
                void'(wq.pop_front());
            end
            if (busy && !pb) begin
                if (gq.size() == 0) flag("unexpected_grant");
                else chk("grant_id", grant_id, gq.pop_front());
            end
            if (timeout_err) begin
                if (tq.size() == 0) flag("unexpected_timeout");
                else chk("timeout_cycle", cyc, tq.pop_front());
            end else if (tq.size() != 0 && tq[0] <= cyc) begin
                flag("missing_timeout");
                void'(tq.pop_front());
            end
            pb = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send(input int c, input logic [31:0] a, input logic [31:0] d, input logic l);
        int n = 0;
        req_valid[c] = 1'b1;
        req_last[c]  = l;
        ch_addr[c]   = a;
        ch_data[c]   = d;
        while (!req_ready[c] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[c]) flag("ready_timeout");
        else wq.push_back('{cyc + 1, a, d});
        @(negedge clk);
        req_valid[c] = 1'b0;
    endtask

    task automatic burst(input int c, input int n, input logic [31:0] base, input logic [31:0] d0,
                         input int gap_at, input int gap, input bit last_en);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) repeat (gap) @(negedge clk);
            send(c, base + 32'(4 * i), d0 + 32'(i), last_en && i == n - 1);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        chk("writes_drained", wq.size(), 0);
        chk("grants_drained", gq.size(), 0);
        chk("timeouts_drained", tq.size(), 0);
        chk("idle_after", busy, 0);
    endtask

    task automatic check_zero(input string n);
        chk({n, "_we"}, bram_we, 0);
        chk({n, "_ena"}, ena, 0);
        chk({n, "_addr"}, bram_addr, 0);
        chk({n, "_data"}, bram_data_in, 0);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_grant"}, grant_id, 0);
        chk({n, "_terr"}, timeout_err, 0);
        chk({n, "_ready"}, req_ready, 0);
    endtask

    initial begin
        int c0, n0;
        req_valid = '0;
        req_last  = '0;
        ch_addr   = '{default: '0};
        ch_data   = '{default: '0};
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        // 11-beat ch0 burst: one arbitration cycle, then 11 consecutive writes.
        c0 = cyc;
        n0 = nwr;
        gq.push_back(0);
        burst(0, 11, 32'h554, 32'd1, -1, 0, 1'b1);
        settle(3);
        chk("burst11_count", nwr - n0, 11);
        chk("burst11_last_cycle", last_wr, c0 + 12);
        // Simultaneous requests after reset: ch0 first, then ch1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gq.push_back(0);
        gq.push_back(1);
        fork
            burst(0, 3, 32'h100, 32'h10, -1, 0, 1'b1);
            burst(1, 3, 32'h200, 32'h20, -1, 0, 1'b1);
        join
        settle(3);
        // ch0 re-requests continuously; ch1 must get the port in between.
        gq.push_back(0);
        gq.push_back(1);
        gq.push_back(0);
        gq.push_back(0);
        fork
            for (int b = 0; b < 3; b++) burst(0, 2, 32'h300 + 32'(16 * b), 32'h30 + 32'(4 * b), -1, 0, 1'b1);
            burst(1, 2, 32'h400, 32'h40, -1, 0, 1'b1);
        join
        settle(3);
        // ch1 stalls 3 cycles mid-burst: exactly 3 write-free cycles, no error.
        gq.push_back(1);
        burst(1, 5, 32'h500, 32'h50, 2, 3, 1'b1);
        settle(3);
        // ch0 stalls forever after 2 beats: forced release after TIMEOUT-1 idle cycles, then ch1.
        gq.push_back(0);
        gq.push_back(1);
        fork
            begin
                burst(0, 2, 32'h600, 32'h60, -1, 0, 1'b0);
                tq.push_back(cyc + TO - 1);
            end
            burst(1, 2, 32'h700, 32'h70, -1, 0, 1'b1);
        join
        settle(3);
        // Single-beat ch0 burst leaves rr_ptr at 0, then reset during beat 5 of a ch0 burst.
        gq.push_back(0);
        burst(0, 1, 32'h880, 32'h88, -1, 0, 1'b1);
        settle(2);
        gq.push_back(0);
        burst(0, 4, 32'h800, 32'h80, -1, 0, 1'b0);
        req_valid[0] = 1'b1;
        req_last[0]  = 1'b0;
        ch_addr[0]   = 32'h810;
        ch_data[0]   = 32'h84;
        rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        gq.push_back(0);
        gq.push_back(1);
        fork
            burst(0, 1, 32'h900, 32'h90, -1, 0, 1'b1);
            burst(1, 1, 32'hA00, 32'hA0, -1, 0, 1'b1);
        join
        settle(3);
`ifdef ARB_GRANT_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 3; b++) begin
            gq.push_back(0);
            burst(0, 2, 32'hB00 + 32'(16 * b), 32'hB0 + 32'(4 * b), -1, 0, 1'b1);
        end
        gq.push_back(0);
        burst(0, 1, 32'hC00, 32'hC0, -1, 0, 1'b0);
        tq.push_back(cyc + TO - 1);
        settle(TO + 2);
        chk("grant_cnt0", grant_cnt[31:0], 3);
        chk("grant_cnt1", grant_cnt[63:32], 0);
        chk("timeout_cnt", timeout_cnt, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
